// File: rtl/dcache_controller.sv
// Two-way set-associative, write-through, read-allocate data cache between MEM and SRAM controller.
// Define DCACHE_STATS_EN to add saturating read hit/miss counters (hit_cnt, miss_cnt).
module dcache_controller #(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned SET_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned NumSets = 1 << SET_BITS;
  localparam int unsigned TagW    = ADDR_W - SET_BITS - 3;

  typedef enum logic [2:0] {StIdle, StRdMiss, StWr, StFill, StResp} state_e;

  state_e             state_q, state_d;
  logic [NumSets-1:0] valid_q [2];
  logic [NumSets-1:0] valid_d [2];
  logic [NumSets-1:0] lru_q, lru_d;
  logic [63:0]        fill_q, fill_d;
  logic               rd_q, rd_d;

  // Tag/data arrays carry no reset; valid bits gate every use.
  logic [TagW-1:0]    tag_mem  [2][NumSets];
  logic [63:0]        data_mem [2][NumSets];

  logic [SET_BITS-1:0] idx;
  logic [TagW-1:0]     tag;
  logic                word_sel, hit0, hit1, hit, hit_way, victim, req_w, req_r;
  logic [63:0]         hit_line;
  logic                unused_addr;

  assign idx         = addr[SET_BITS+2:3];
  assign tag         = addr[ADDR_W-1:SET_BITS+3];
  assign word_sel    = addr[2];
  assign unused_addr = ^addr[1:0];
  assign req_w       = MEM_W_EN;
  assign req_r       = MEM_R_EN & ~MEM_W_EN;

  assign hit0     = valid_q[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1     = valid_q[1][idx] && (tag_mem[1][idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign hit_line = hit0 ? data_mem[0][idx] : data_mem[1][idx];
  assign victim   = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);

  always_comb begin
    state_d    = state_q;
    valid_d[0] = valid_q[0];
    valid_d[1] = valid_q[1];
    lru_d      = lru_q;
    fill_d     = fill_q;
    rd_d       = rd_q;
    unique case (state_q)
      StIdle: begin
        if (req_w) begin
          state_d = StWr;
          rd_d    = 1'b0;
        end else if (req_r) begin
          if (hit) begin
            lru_d[idx] = ~hit_way;
          end else begin
            state_d = StRdMiss;
            rd_d    = 1'b1;
          end
        end
      end
      StRdMiss: begin
        if (sram_ready) begin
          fill_d  = sram_rdata;
          state_d = StFill;
        end
      end
      StFill: begin
        valid_d[victim][idx] = 1'b1;
        lru_d[idx]           = ~victim;
        state_d              = StResp;
      end
      StWr: begin
        if (sram_ready) begin
          if (hit) lru_d[idx] = ~hit_way;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
      fill_q     <= '0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q[0] <= valid_d[0];
      valid_q[1] <= valid_d[1];
      lru_q      <= lru_d;
      fill_q     <= fill_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StFill) begin
      tag_mem[victim][idx]  <= tag;
      data_mem[victim][idx] <= fill_q;
    end else if (state_q == StWr && sram_ready && hit) begin
      if (word_sel) data_mem[hit_way][idx][63:32] <= wdata;
      else          data_mem[hit_way][idx][31:0]  <= wdata;
    end
  end

  always_comb begin
    ready = 1'b0;
    rdata = '0;
    if (state_q == StIdle) begin
      ready = ~req_w & ~(req_r & ~hit);
      if (hit) rdata = word_sel ? hit_line[63:32] : hit_line[31:0];
    end else if (state_q == StResp) begin
      ready = 1'b1;
      if (rd_q) rdata = word_sel ? fill_q[63:32] : fill_q[31:0];
    end
  end

  assign sram_r_en  = (state_q == StRdMiss);
  assign sram_w_en  = (state_q == StWr);
  assign sram_addr  = sram_w_en ? {addr[31:2], 2'b00} : {addr[31:3], 3'b000};
  assign sram_wdata = wdata;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StIdle && req_r && hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == StResp && rd_q && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: stimulus queues expected load data, a monitor checks it.
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] addr, wdata, rdata;
  logic        ready, sram_r_en, sram_w_en;
  logic [31:0] sram_addr, sram_wdata;
  logic [63:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .MEM_R_EN  (MEM_R_EN),
    .MEM_W_EN  (MEM_W_EN),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .sram_r_en (sram_r_en),
    .sram_w_en (sram_w_en),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_ready(sram_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SRAM model: answers after `lat` request cycles, driven on the falling edge.
  logic [31:0] mem [logic [31:0]];
  int          lat = 1;
  int          cnt = 0;
  int          r_cycles = 0, w_cycles = 0;
  logic        both_seen = 1'b0;
  logic [31:0] last_addr = '0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (32'hA000_0000 | a);
  endfunction

  always @(negedge clk) begin
    if (sram_r_en || sram_w_en) begin
      cnt++;
      last_addr = sram_addr;
      if (sram_r_en) r_cycles++;
      if (sram_w_en) w_cycles++;
      if (sram_r_en && sram_w_en) both_seen = 1'b1;
      sram_rdata = {rd_word(sram_addr + 32'd4), rd_word(sram_addr)};
      sram_ready = (cnt >= lat);
      if (sram_ready && sram_w_en) mem[sram_addr] = sram_wdata;
    end else begin
      cnt        = 0;
      sram_ready = 1'b0;
    end
  end

  // Monitor: every completed load pops one expected word.
  always begin
    @(posedge clk);
    #8;
    if (!rst && ready && MEM_R_EN && !MEM_W_EN) begin
      if (exp_q.size() == 0) begin
        chk("rdata_unexpected", {32'h0, rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("rdata", {32'h0, rdata}, {32'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic clr_counts();
    r_cycles  = 0;
    w_cycles  = 0;
    both_seen = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 with the request released.
  task automatic wait_done(input string nm, output int low);
    bit done = 0;
    low = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      #6;
      if (ready) done = 1;
      else begin
        low++;
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input int exp_low,
                         input int exp_r);
    int low;
    clr_counts();
    exp_q.push_back(exp);
    MEM_R_EN = 1'b1;
    MEM_W_EN = 1'b0;
    addr     = a;
    wait_done("rd", low);
    chk("rd_low_cycles", low, exp_low);
    chk("rd_sram_r_cycles", r_cycles, exp_r);
    chk("rd_no_sram_w", w_cycles, 0);
    if (exp_r > 0) chk("rd_sram_addr", last_addr, {a[31:3], 3'b000});
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int exp_low,
                          input int exp_w, input logic also_rd);
    int low;
    clr_counts();
    MEM_W_EN = 1'b1;
    MEM_R_EN = also_rd;
    addr     = a;
    wdata    = d;
    wait_done("wr", low);
    chk("wr_low_cycles", low, exp_low);
    chk("wr_sram_w_cycles", w_cycles, exp_w);
    chk("wr_sram_addr", last_addr, {a[31:2], 2'b00});
    chk("wr_no_sram_r", r_cycles, 0);
    chk("wr_never_both", both_seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    addr     = '0;
    wdata    = '0;
    mem[32'h400] = 32'h1111_1111;
    mem[32'h404] = 32'h2222_2222;

    #12;
    chk("reset_ready", ready, 1);
    chk("reset_sram_r_en", sram_r_en, 0);
    chk("reset_sram_w_en", sram_w_en, 0);
`ifdef DCACHE_STATS_EN
    chk("reset_hit_cnt", hit_cnt, 0);
    chk("reset_miss_cnt", miss_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold read, then a hit on the other word of the filled line
    lat = 3;
    do_read(32'h400, 32'h1111_1111, 5, 3);
    lat = 1;
    do_read(32'h404, 32'h2222_2222, 0, 0);
`ifdef DCACHE_STATS_EN
    chk("stats_hit_cnt", hit_cnt, 1);
    chk("stats_miss_cnt", miss_cnt, 1);
`endif

    // Store to a cached word updates the line
    lat = 2;
    do_write(32'h404, 32'hDEAD_BEEF, 3, 2, 1'b0);
    do_read(32'h404, 32'hDEAD_BEEF, 0, 0);

    // Store to an uncached word does not allocate
    lat = 1;
    do_write(32'h804, 32'h1234_5678, 2, 1, 1'b0);
    do_read(32'h804, 32'h1234_5678, 3, 1);

    // Read and write requested together: write only
    lat = 2;
    do_write(32'h408, 32'h55AA_55AA, 3, 2, 1'b1);
    do_read(32'h408, 32'h55AA_55AA, 4, 2);

    // Reset in the middle of a line read
    lat = 10;
    clr_counts();
    MEM_R_EN = 1'b1;
    addr     = 32'h600;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("miss_in_progress", sram_r_en, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_sram_r_en", sram_r_en, 0);
    chk("rst_async_sram_w_en", sram_w_en, 0);
    MEM_R_EN = 1'b0;
    #1;
    chk("rst_idle_ready", ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 1;
    do_read(32'h404, 32'hDEAD_BEEF, 3, 1);

    // LRU replacement in set 0 from a clean cache
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    lat = 2;
    do_read(32'h000, 32'hA000_0000, 4, 2);
    do_read(32'h200, 32'hA000_0200, 4, 2);
    do_read(32'h400, 32'h1111_1111, 4, 2);
    do_read(32'h000, 32'hA000_0000, 4, 2);
    do_read(32'h400, 32'h1111_1111, 0, 0);
    do_read(32'h200, 32'hA000_0200, 4, 2);
`ifdef DCACHE_STATS_EN
    chk("final_hit_cnt", hit_cnt, 1);
    chk("final_miss_cnt", miss_cnt, 5);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
